// File: rtl/multicore_io_sched.sv
// Shared-I/O scheduler: holds one broadcast input sample for the core array and
// serialises per-core result strobes onto one valid/ready stream (round-robin).
module multicore_io_sched #(
    parameter int N_CORES = 76,
    parameter int DW      = 31,
    parameter int IDX_W   = 7
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic signed [DW-1:0]     src_data,
    input  logic                     src_valid,
    output logic                     src_ready,
    output logic signed [DW-1:0]     core_in,
    output logic                     core_in_valid,
    input  logic [N_CORES-1:0]       req_in,
    input  logic [N_CORES*DW-1:0]    core_out,
    input  logic [N_CORES-1:0]       out_en,
    output logic signed [DW-1:0]     out_data,
    output logic [IDX_W-1:0]         out_core,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N_CORES-1:0]       overflow
);

    logic signed [DW-1:0] sample_q, sample_d;
    logic                 sample_vld_q, sample_vld_d;
    logic [DW-1:0]        hold_data_q [N_CORES];
    logic [DW-1:0]        hold_data_d [N_CORES];
    logic [N_CORES-1:0]   hold_vld_q, hold_vld_d;
    logic [N_CORES-1:0]   overflow_q, overflow_d;
    logic [IDX_W-1:0]     last_grant_q, last_grant_d;
    logic signed [DW-1:0] out_data_q, out_data_d;
    logic [IDX_W-1:0]     out_core_q, out_core_d;
    logic                 out_valid_q, out_valid_d;

    logic                 consume;
    logic                 load_ok;
    logic [N_CORES-1:0]   upper_mask;
    logic [N_CORES-1:0]   upper_req;
    logic [IDX_W-1:0]     grant_idx;
    logic                 grant_vld;

    assign consume   = sample_vld_q & (|req_in);
    assign src_ready = ~sample_vld_q | consume;
    assign load_ok   = ~out_valid_q | out_ready;

    // Round-robin: lowest requester above last_grant wins, else lowest overall (wrap).
    always_comb begin
        for (int i = 0; i < N_CORES; i++) begin
            upper_mask[i] = (IDX_W'(i) > last_grant_q);
        end
        upper_req = hold_vld_q & upper_mask;
        grant_idx = '0;
        for (int i = N_CORES - 1; i >= 0; i--) begin
            if (hold_vld_q[i]) grant_idx = IDX_W'(i);
        end
        for (int i = N_CORES - 1; i >= 0; i--) begin
            if (upper_req[i]) grant_idx = IDX_W'(i);
        end
        grant_vld = load_ok & (|hold_vld_q);
    end

    always_comb begin
        sample_d     = sample_q;
        sample_vld_d = sample_vld_q;
        hold_data_d  = hold_data_q;
        hold_vld_d   = hold_vld_q;
        overflow_d   = overflow_q;
        last_grant_d = last_grant_q;
        out_data_d   = out_data_q;
        out_core_d   = out_core_q;
        out_valid_d  = out_valid_q;

        if (src_valid && src_ready) begin
            sample_d     = src_data;
            sample_vld_d = 1'b1;
        end else if (consume) begin
            sample_vld_d = 1'b0;
        end

        if (grant_vld) begin
            out_data_d             = hold_data_q[grant_idx];
            out_core_d             = grant_idx;
            out_valid_d            = 1'b1;
            last_grant_d           = grant_idx;
            hold_vld_d[grant_idx]  = 1'b0;
        end else if (load_ok) begin
            out_valid_d = 1'b0;
        end

        // Grant clears the slot first, so a strobe on the granted core reloads it.
        for (int i = 0; i < N_CORES; i++) begin
            if (out_en[i]) begin
                if (!hold_vld_d[i]) begin
                    hold_data_d[i] = core_out[i*DW +: DW];
                    hold_vld_d[i]  = 1'b1;
                end else begin
                    overflow_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_q     <= '0;
            sample_vld_q <= 1'b0;
            for (int i = 0; i < N_CORES; i++) begin
                hold_data_q[i] <= '0;
            end
            hold_vld_q   <= '0;
            overflow_q   <= '0;
            last_grant_q <= IDX_W'(N_CORES - 1);
            out_data_q   <= '0;
            out_core_q   <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            sample_q     <= sample_d;
            sample_vld_q <= sample_vld_d;
            hold_data_q  <= hold_data_d;
            hold_vld_q   <= hold_vld_d;
            overflow_q   <= overflow_d;
            last_grant_q <= last_grant_d;
            out_data_q   <= out_data_d;
            out_core_q   <= out_core_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign core_in       = sample_q;
    assign core_in_valid = sample_vld_q;
    assign out_data      = out_data_q;
    assign out_core      = out_core_q;
    assign out_valid     = out_valid_q;
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_multicore_io_sched.sv
// Directed and randomized bench for multicore_io_sched, checked each cycle
// against a queue-free behavioural model of the input holder, slots and arbiter.
module tb_multicore_io_sched;

    localparam int N     = 76;
    localparam int DW    = 31;
    localparam int IDX_W = 7;

    logic                  clk = 1'b0;
    logic                  rstN;
    logic signed [DW-1:0]  srcData;
    logic                  srcValid;
    logic                  srcReady;
    logic signed [DW-1:0]  coreIn;
    logic                  coreInValid;
    logic [N-1:0]          reqIn;
    logic [N*DW-1:0]       coreOut;
    logic [N-1:0]          outEn;
    logic signed [DW-1:0]  outData;
    logic [IDX_W-1:0]      outCore;
    logic                  outValid;
    logic                  outReady;
    logic [N-1:0]          overflow;

    int checks = 0;
    int errors = 0;

    logic signed [DW-1:0]  mSample;
    bit                    mSampleVld;
    logic signed [DW-1:0]  mHold [N];
    bit                    mHoldVld [N];
    logic [N-1:0]          mOvf;
    int                    mLast;
    logic signed [DW-1:0]  mOutData;
    int                    mOutCore;
    bit                    mOutValid;

    multicore_io_sched #(.N_CORES(N), .DW(DW), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst_n(rstN),
        .src_data(srcData), .src_valid(srcValid), .src_ready(srcReady),
        .core_in(coreIn), .core_in_valid(coreInValid),
        .req_in(reqIn), .core_out(coreOut), .out_en(outEn),
        .out_data(outData), .out_core(outCore), .out_valid(outValid),
        .out_ready(outReady), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic checkValue(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic modelReset();
        mSample    = '0;
        mSampleVld = 1'b0;
        for (int i = 0; i < N; i++) begin
            mHold[i]    = '0;
            mHoldVld[i] = 1'b0;
        end
        mOvf      = '0;
        mLast     = N - 1;
        mOutData  = '0;
        mOutCore  = 0;
        mOutValid = 1'b0;
    endtask

    // One clock edge of the scheduler, computed from the current inputs.
    task automatic modelStep();
        bit consume;
        bit srcRdy;
        bit loadOk;
        int g;
        int c;
        consume = mSampleVld && (reqIn != '0);
        srcRdy  = !mSampleVld || consume;
        loadOk  = !mOutValid || outReady;
        g = -1;
        if (loadOk) begin
            for (int k = 1; k <= N; k++) begin
                c = (mLast + k) % N;
                if (g < 0 && mHoldVld[c]) g = c;
            end
        end
        if (g >= 0) begin
            mOutData    = mHold[g];
            mOutCore    = g;
            mOutValid   = 1'b1;
            mLast       = g;
            mHoldVld[g] = 1'b0;
        end else if (loadOk) begin
            mOutValid = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            if (outEn[i]) begin
                if (!mHoldVld[i]) begin
                    mHold[i]    = coreOut[i*DW +: DW];
                    mHoldVld[i] = 1'b1;
                end else begin
                    mOvf[i] = 1'b1;
                end
            end
        end
        if (srcValid && srcRdy) begin
            mSample    = srcData;
            mSampleVld = 1'b1;
        end else if (consume) begin
            mSampleVld = 1'b0;
        end
    endtask

    task automatic checkOutput(input string tag);
        bit expRdy;
        expRdy = !mSampleVld || (reqIn != '0);
        checkValue({tag, ".src_ready"}, srcReady, expRdy);
        checkValue({tag, ".core_in"}, coreIn, mSample);
        checkValue({tag, ".core_in_valid"}, coreInValid, mSampleVld);
        checkValue({tag, ".out_valid"}, outValid, mOutValid);
        checkValue({tag, ".out_data"}, outData, mOutData);
        checkValue({tag, ".out_core"}, outCore, mOutCore);
        checkValue({tag, ".overflow"}, overflow, mOvf);
    endtask

    task automatic applyStimulus(input bit sv, input logic signed [DW-1:0] sd,
                                 input logic [N-1:0] req, input logic [N-1:0] en, input bit rdy);
        srcValid = sv;
        srcData  = sd;
        reqIn    = req;
        outEn    = en;
        outReady = rdy;
    endtask

    task automatic runCycle(input string tag);
        #1;
        checkOutput(tag);
        @(posedge clk);
        modelStep();
        @(negedge clk);
    endtask

    initial begin
        logic [N-1:0] req;
        logic [N-1:0] en;
        logic [N-1:0] ovfExp;

        rstN = 1'b0;
        coreOut = '0;
        applyStimulus(1'b0, '0, '0, '0, 1'b0);
        modelReset();
        #1;
        checkOutput("reset");
        checkValue("reset.last_prio_src_ready", srcReady, 1'b1);
        @(negedge clk);
        rstN = 1'b1;

        // Input holder: load, then consume-and-refill with two requesters.
        applyStimulus(1'b1, -31'sd5, '0, '0, 1'b1);
        runCycle("load");
        checkValue("load.core_in", coreIn, -5);
        checkValue("load.src_ready", srcReady, 1'b0);
        req = '0; req[3] = 1'b1; req[9] = 1'b1;
        applyStimulus(1'b1, 31'sd17, req, '0, 1'b1);
        runCycle("refill");
        checkValue("refill.core_in", coreIn, 17);
        checkValue("refill.core_in_valid", coreInValid, 1'b1);
        applyStimulus(1'b0, '0, '0, '0, 1'b1);
        runCycle("idle");

        // Three simultaneous strobes drain on consecutive cycles.
        en = '0; en[0] = 1'b1; en[5] = 1'b1; en[75] = 1'b1;
        coreOut[0*DW +: DW]  = 31'sd100;
        coreOut[5*DW +: DW]  = 31'sd200;
        coreOut[75*DW +: DW] = -31'sd300;
        applyStimulus(1'b0, '0, '0, en, 1'b1);
        runCycle("strobe3");
        applyStimulus(1'b0, '0, '0, '0, 1'b1);
        runCycle("drain0");
        checkValue("drain0.valid", outValid, 1'b1);
        checkValue("drain0.core", outCore, 0);
        checkValue("drain0.data", outData, 100);
        runCycle("drain1");
        checkValue("drain1.core", outCore, 5);
        checkValue("drain1.data", outData, 200);
        runCycle("drain2");
        checkValue("drain2.core", outCore, 75);
        checkValue("drain2.data", outData, -300);
        runCycle("drain3");
        checkValue("drain3.valid", outValid, 1'b0);

        // Backpressure holds the output register stable.
        en = '0; en[10] = 1'b1; en[20] = 1'b1; en[30] = 1'b1;
        for (int i = 0; i < N; i++) coreOut[i*DW +: DW] = DW'($urandom);
        applyStimulus(1'b0, '0, '0, en, 1'b1);
        runCycle("bp.strobe");
        applyStimulus(1'b0, '0, '0, '0, 1'b1);
        runCycle("bp.first");
        applyStimulus(1'b0, '0, '0, '0, 1'b0);
        for (int i = 0; i < 4; i++) runCycle("bp.stall");
        checkValue("bp.stall.core", outCore, 10);
        applyStimulus(1'b0, '0, '0, '0, 1'b1);
        for (int i = 0; i < 4; i++) runCycle("bp.release");

        // Overflow on core 2 while the output is stalled.
        en = '0; en[40] = 1'b1;
        coreOut[40*DW +: DW] = 31'sd400;
        applyStimulus(1'b0, '0, '0, en, 1'b0);
        runCycle("ovf.fill");
        applyStimulus(1'b0, '0, '0, '0, 1'b0);
        runCycle("ovf.stuck");
        en = '0; en[2] = 1'b1;
        coreOut[2*DW +: DW] = 31'sd11;
        applyStimulus(1'b0, '0, '0, en, 1'b0);
        runCycle("ovf.first");
        coreOut[2*DW +: DW] = 31'sd22;
        runCycle("ovf.second");
        applyStimulus(1'b0, '0, '0, '0, 1'b0);
        runCycle("ovf.hold");
        ovfExp = '0; ovfExp[2] = 1'b1;
        checkValue("ovf.flag", overflow, ovfExp);
        applyStimulus(1'b0, '0, '0, '0, 1'b1);
        runCycle("ovf.rel");
        checkValue("ovf.rel.core", outCore, 2);
        checkValue("ovf.rel.data", outData, 11);
        runCycle("ovf.empty");
        checkValue("ovf.empty.valid", outValid, 1'b0);

        // Every core strobes once per 76-cycle round.
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < N; i++) coreOut[i*DW +: DW] = DW'($urandom);
            applyStimulus(1'b0, '0, '0, '1, 1'b1);
            runCycle("round.strobe");
            applyStimulus(1'b0, '0, '0, '0, 1'b1);
            for (int i = 0; i < N - 1; i++) runCycle("round.drain");
        end
        runCycle("round.tail");
        checkValue("round.overflow", overflow, ovfExp);

        // Asynchronous reset with results pending.
        en = '0; en[7] = 1'b1; en[8] = 1'b1; en[9] = 1'b1; en[11] = 1'b1;
        applyStimulus(1'b0, '0, '0, en, 1'b0);
        runCycle("mrst.strobe");
        applyStimulus(1'b0, '0, '0, '0, 1'b0);
        runCycle("mrst.pending");
        checkValue("mrst.pending.valid", outValid, 1'b1);
        #3;
        rstN = 1'b0;
        #1;
        modelReset();
        checkValue("mrst.out_valid", outValid, 1'b0);
        checkValue("mrst.out_data", outData, 0);
        checkValue("mrst.out_core", outCore, 0);
        checkValue("mrst.core_in_valid", coreInValid, 1'b0);
        checkValue("mrst.overflow", overflow, 0);
        checkOutput("mrst");
        @(posedge clk);
        @(negedge clk);
        rstN = 1'b1;
        applyStimulus(1'b0, '0, '0, '0, 1'b1);
        for (int i = 0; i < 5; i++) runCycle("mrst.after");
        checkValue("mrst.after.valid", outValid, 1'b0);

        // Randomized traffic on both sides.
        for (int c = 0; c < 400; c++) begin
            req = '0;
            if ($urandom_range(0, 2) == 0) req[$urandom_range(0, N - 1)] = 1'b1;
            if ($urandom_range(0, 4) == 0) req[$urandom_range(0, N - 1)] = 1'b1;
            en = '0;
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 19) == 0) en[i] = 1'b1;
                coreOut[i*DW +: DW] = DW'($urandom);
            end
            applyStimulus(1'(($urandom) & 1), DW'($urandom), req, en, ($urandom_range(0, 3) != 0));
            runCycle("rand");
        end
        applyStimulus(1'b0, '0, '0, '0, 1'b1);
        for (int i = 0; i < N + 2; i++) runCycle("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
